// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants and the multiply/divide unit's state type.
package riscv_pkg;

  localparam logic [6:0] OPCODE_RTYPE  = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_DONE = 2'd3
  } md_state_t;

endpackage

// File: rtl/md_div_core.sv
// Unsigned radix-2 restoring divider iterator: one quotient bit per step, MSB first.
// quotient_o/remainder_o present the values the current step would produce, so the
// owner can capture the final result on the same edge as the last step.
module md_div_core
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;

  // One restoring step: shift in next dividend bit, trial-subtract, keep if no borrow.
  always_comb begin
    rem_sh = {rem_q, quo_q[XLEN-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    if (!diff[XLEN]) begin
      rem_d = diff[XLEN-1:0];
      quo_d = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_d = rem_sh[XLEN-1:0];
      quo_d = {quo_q[XLEN-2:0], 1'b0};
    end
  end

  assign quotient_o  = quo_d;
  assign remainder_o = rem_d;

  // Iterator registers: load seeds the dividend into the quotient shifter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (load_i) begin
      quo_q <= dividend_i;
      rem_q <= '0;
      dvs_q <= divisor_i;
    end else if (step_i) begin
      quo_q <= quo_d;
      rem_q <= rem_d;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Execute-stage RV32M unit: 2-cycle multiply, 33-cycle restoring divide with
// early-out for divide-by-zero and signed overflow. Stalls the pipe while busy.
module ex_muldiv_unit
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [6:0]      ex_opcode,
  input  logic [6:0]      ex_func7,
  input  logic [2:0]      ex_func3,
  input  logic [XLEN-1:0] ex_op1,
  input  logic [XLEN-1:0] ex_op2,
  input  logic [4:0]      ex_wb_rd,
  output logic            md_stall,
  output logic            md_valid,
  output logic [XLEN-1:0] md_result,
  output logic [4:0]      md_rd
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t state_q, state_d;

  logic [2:0]      f3_q, f3_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] op1_q, op1_d;
  logic [XLEN-1:0] op2_q, op2_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      mdrd_q, mdrd_d;

  logic            is_m;
  logic            start;
  logic            div_signed;
  logic            div_zero;
  logic            div_ovf;
  logic            op1_neg;
  logic            op2_neg;
  logic [XLEN-1:0] abs1;
  logic [XLEN-1:0] abs2;
  logic [XLEN-1:0] special_res;

  logic            div_load;
  logic            div_step;
  logic [XLEN-1:0] core_quo;
  logic [XLEN-1:0] core_rem;
  logic [XLEN-1:0] fin_quo;
  logic [XLEN-1:0] fin_rem;
  logic [XLEN-1:0] div_res;

  logic            mul_a_sgn;
  logic            mul_b_sgn;
  logic [2*XLEN-1:0] mul_a;
  logic [2*XLEN-1:0] mul_b;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] mul_res;

  // Decode of the instruction currently in EX, including divide early-out detection.
  always_comb begin
    is_m       = (ex_opcode == OPCODE_RTYPE) && (ex_func7 == FUNCT7_MULDIV);
    start      = is_m && (state_q == MD_IDLE) && !flush;
    div_signed = !ex_func3[0];
    div_zero   = (ex_op2 == '0);
    div_ovf    = div_signed && (ex_op1 == INT_MIN) && (ex_op2 == '1);
    op1_neg    = div_signed && ex_op1[XLEN-1];
    op2_neg    = div_signed && ex_op2[XLEN-1];
    abs1       = op1_neg ? -ex_op1 : ex_op1;
    abs2       = op2_neg ? -ex_op2 : ex_op2;
    if (div_zero) begin
      special_res = ex_func3[1] ? ex_op1 : '1;
    end else begin
      special_res = ex_func3[1] ? '0 : INT_MIN;
    end
  end

  // Multiplier: the 33-bit extended operands are widened to 2*XLEN, which yields
  // the same low 2*XLEN product bits as the full 66-bit signed product.
  always_comb begin
    mul_a_sgn = ((f3_q == F3_MULH) || (f3_q == F3_MULHSU)) && op1_q[XLEN-1];
    mul_b_sgn = (f3_q == F3_MULH) && op2_q[XLEN-1];
    mul_a     = {{XLEN{mul_a_sgn}}, op1_q};
    mul_b     = {{XLEN{mul_b_sgn}}, op2_q};
    prod      = mul_a * mul_b;
    mul_res   = (f3_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  md_div_core #(
    .XLEN(XLEN)
  ) u_div (
    .clk         (clk),
    .rst         (rst),
    .load_i      (div_load),
    .step_i      (div_step),
    .dividend_i  (abs1),
    .divisor_i   (abs2),
    .quotient_o  (core_quo),
    .remainder_o (core_rem)
  );

  // Divide sign fix on the final step's magnitudes.
  always_comb begin
    fin_quo = negq_q ? -core_quo : core_quo;
    fin_rem = negr_q ? -core_rem : core_rem;
    div_res = f3_q[1] ? fin_rem : fin_quo;
  end

  // Next-state and datapath control; flush overrides everything except reset.
  always_comb begin
    state_d  = state_q;
    f3_d     = f3_q;
    rd_d     = rd_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    mdrd_d   = mdrd_q;
    div_load = 1'b0;
    div_step = 1'b0;
    if (flush) begin
      state_d = MD_IDLE;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (start) begin
            f3_d  = ex_func3;
            rd_d  = ex_wb_rd;
            op1_d = ex_op1;
            op2_d = ex_op2;
            if (!ex_func3[2]) begin
              state_d = MD_MUL;
            end else if (div_zero || div_ovf) begin
              result_d = special_res;
              mdrd_d   = ex_wb_rd;
              state_d  = MD_DONE;
            end else begin
              div_load = 1'b1;
              negq_d   = op1_neg ^ op2_neg;
              negr_d   = op1_neg;
              cnt_d    = CW'(XLEN - 1);
              state_d  = MD_DIV;
            end
          end
        end
        MD_MUL: begin
          result_d = mul_res;
          mdrd_d   = rd_q;
          state_d  = MD_DONE;
        end
        MD_DIV: begin
          div_step = 1'b1;
          if (cnt_q == '0) begin
            result_d = div_res;
            mdrd_d   = rd_q;
            state_d  = MD_DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        MD_DONE: begin
          state_d = MD_IDLE;
        end
        default: begin
          state_d = MD_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MD_IDLE;
      f3_q     <= '0;
      rd_q     <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      mdrd_q   <= '0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      rd_q     <= rd_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      mdrd_q   <= mdrd_d;
    end
  end

  // Stall drops in DONE so the EX instruction retires on that edge.
  always_comb begin
    md_stall  = !flush && (start || (state_q == MD_MUL) || (state_q == MD_DIV));
    md_valid  = !flush && (state_q == MD_DONE);
    md_result = result_q;
    md_rd     = mdrd_q;
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Randomized scoreboard bench for ex_muldiv_unit against an arithmetic reference model.
module tb_ex_muldiv_unit;

  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] F7_M   = 7'b0000001;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [6:0]  ex_opcode;
  logic [6:0]  ex_func7;
  logic [2:0]  ex_func3;
  logic [31:0] ex_op1;
  logic [31:0] ex_op2;
  logic [4:0]  ex_wb_rd;
  logic        md_stall;
  logic        md_valid;
  logic [31:0] md_result;
  logic [4:0]  md_rd;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int unsigned cyc;
  } exp_t;

  exp_t        scb[$];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned passes = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ex_muldiv_unit #(
    .XLEN(32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .ex_opcode (ex_opcode),
    .ex_func7  (ex_func7),
    .ex_func3  (ex_func3),
    .ex_op1    (ex_op1),
    .ex_op2    (ex_op2),
    .ex_wb_rd  (ex_wb_rd),
    .md_stall  (md_stall),
    .md_valid  (md_valid),
    .md_result (md_result),
    .md_rd     (md_rd)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
  endtask

  // RV32M results straight from integer arithmetic.
  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
    longint          sa, sbv, p;
    longint unsigned ua, ub, pu;
    int              ia, ib;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    case (f3)
      3'd0: begin p = sa * sbv; return p[31:0]; end
      3'd1: begin p = sa * sbv; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin pu = ua * ub; return pu[63:32]; end
      default: begin
        if (b == 32'h0) return f3[1] ? a : 32'hFFFF_FFFF;
        if (!f3[0]) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'h0 : a;
          ia = a;
          ib = b;
          return f3[1] ? 32'(ia % ib) : 32'(ia / ib);
        end
        return f3[1] ? (a % b) : (a / b);
      end
    endcase
  endfunction

  function automatic int unsigned ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    if (!f3[2]) return 2;
    if (b == 32'h0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic bubble();
    ex_opcode = OPC_I;
    ex_func7  = 7'h00;
    ex_func3  = 3'd0;
    ex_op1    = 32'h0;
    ex_op2    = 32'h0;
    ex_wb_rd  = 5'd0;
  endtask

  // Hold the instruction in EX until a cycle with md_stall low lets it retire.
  task automatic wait_retire(input int unsigned lat);
    int unsigned n;
    logic        s;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      s = md_stall;
      @(posedge clk);
      #1;
      if (!s) break;
      n++;
    end
    chk("stall cycles", n, lat);
  endtask

  task automatic issue_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit use_exp, input logic [31:0] exp_res);
    exp_t        e;
    int unsigned lat;
    ex_opcode = OPC_R;
    ex_func7  = F7_M;
    ex_func3  = f3;
    ex_op1    = a;
    ex_op2    = b;
    ex_wb_rd  = rd;
    lat   = ref_lat(f3, a, b);
    e.res = use_exp ? exp_res : ref_md(f3, a, b);
    e.rd  = rd;
    e.cyc = cyc + lat;
    scb.push_back(e);
    wait_retire(lat);
  endtask

  task automatic issue_other(input logic [6:0] opc, input logic [6:0] f7, input logic [2:0] f3);
    ex_opcode = opc;
    ex_func7  = f7;
    ex_func3  = f3;
    ex_op1    = $urandom;
    ex_op2    = $urandom;
    ex_wb_rd  = 5'($urandom_range(1, 31));
    wait_retire(0);
  endtask

  // Monitor: every md_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && md_valid === 1'b1) begin
      if (scb.size() == 0) begin
        chk("unexpected md_valid", 32'd1, 32'd0);
      end else begin
        e = scb.pop_front();
        chk("md_result", md_result, e.res);
        chk("md_rd", {27'h0, md_rd}, {27'h0, e.rd});
        chk("valid cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] opc;
    rst   = 1'b1;
    flush = 1'b0;
    bubble();
    #12;
    chk("reset md_valid", {31'h0, md_valid}, 32'h0);
    chk("reset md_stall", {31'h0, md_stall}, 32'h0);
    chk("reset md_result", md_result, 32'h0);
    chk("reset md_rd", {27'h0, md_rd}, 32'h0);
    #5 rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors with literal expectations.
    issue_m(3'd0, 32'd7,         32'hFFFF_FFFD, 5'd1,  1, 32'hFFFF_FFEB);
    issue_m(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2,  1, 32'h4000_0000);
    issue_m(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  1, 32'hFFFF_FFFE);
    issue_m(3'd2, 32'hFFFF_FFFF, 32'd2,         5'd4,  1, 32'hFFFF_FFFF);
    issue_m(3'd4, 32'hFFFF_FFF9, 32'd2,         5'd5,  1, 32'hFFFF_FFFD);
    issue_m(3'd6, 32'hFFFF_FFF9, 32'd2,         5'd6,  1, 32'hFFFF_FFFF);
    issue_m(3'd5, 32'd100,       32'd0,         5'd7,  1, 32'hFFFF_FFFF);
    issue_m(3'd7, 32'd100,       32'd0,         5'd8,  1, 32'd100);
    issue_m(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  1, 32'h8000_0000);
    issue_m(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1, 32'h0);
    issue_m(3'd4, 32'd5,         32'd0,         5'd11, 1, 32'hFFFF_FFFF);
    issue_other(OPC_R, 7'h00, 3'd0);
    issue_other(OPC_I, F7_M, 3'd4);

    // Flush in cycle 10 of a divide: no result, stall drops in the flush cycle.
    ex_opcode = OPC_R;
    ex_func7  = F7_M;
    ex_func3  = 3'd4;
    ex_op1    = 32'd1000;
    ex_op2    = 32'd7;
    ex_wb_rd  = 5'd12;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("stall mid-divide", {31'h0, md_stall}, 32'h1);
    repeat (5) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("stall in flush cycle", {31'h0, md_stall}, 32'h0);
    chk("valid in flush cycle", {31'h0, md_valid}, 32'h0);
    @(posedge clk);
    #1 flush = 1'b0;
    bubble();
    @(negedge clk);
    chk("stall after flush", {31'h0, md_stall}, 32'h0);
    @(posedge clk);
    #1;
    issue_m(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd13, 0, 32'h0);

    // Randomized mix of M and non-M instructions, sometimes with bubbles between.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        opc = $urandom_range(0, 1) ? OPC_R : OPC_I;
        issue_other(opc, (opc == OPC_R) ? ($urandom_range(0, 1) ? 7'h00 : 7'h20) : F7_M,
                    3'($urandom_range(0, 7)));
      end else begin
        issue_m(3'($urandom_range(0, 7)), rand_op(), rand_op(),
                5'($urandom_range(0, 31)), 0, 32'h0);
      end
      if ($urandom_range(0, 3) == 0) begin
        bubble();
        @(posedge clk);
        #1;
      end
    end

    // Asynchronous reset in the middle of a divide.
    ex_opcode = OPC_R;
    ex_func7  = F7_M;
    ex_func3  = 3'd5;
    ex_op1    = 32'hDEAD_BEEF;
    ex_op2    = 32'd3;
    ex_wb_rd  = 5'd14;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    bubble();
    #1;
    chk("async rst md_valid", {31'h0, md_valid}, 32'h0);
    chk("async rst md_stall", {31'h0, md_stall}, 32'h0);
    chk("async rst md_result", md_result, 32'h0);
    chk("async rst md_rd", {27'h0, md_rd}, 32'h0);
    #4 rst = 1'b0;
    @(posedge clk);
    #1;
    issue_m(3'd0, 32'hFFFF_FFFF, 32'h0000_0003, 5'd15, 1, 32'hFFFF_FFFD);
    issue_m(3'd4, 32'd100,       32'hFFFF_FFF9, 5'd16, 1, 32'hFFFF_FFF2);
    issue_m(3'd6, 32'd100,       32'hFFFF_FFF9, 5'd17, 1, 32'd2);
    bubble();

    repeat (3) @(posedge clk);
    chk("scoreboard drained", scb.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
